// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: FIFO-buffered command sequencer that drives one register_8 control per cycle.
module reg_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [7:0]       data,
  output logic             load,
  output logic             reverse,
  output logic             nibble_reverse,
  output logic             rotateleft_b,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  typedef enum logic {IDLE, EXEC} state_t;
  state_t state_q, state_d;
  logic [2:0] op_mem [DEPTH];
  logic [7:0] dat_mem [DEPTH];
  logic [CNT_W-1:0] cnt_mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [OW-1:0] occ_q;
  logic [2:0] op_q;
  logic [7:0] data_q;
  logic [CNT_W-1:0] rem_q;
  logic err_q, empty, push, pop, last, exec;
  assign empty     = occ_q == '0;
  assign cmd_ready = occ_q != OW'(DEPTH);
  assign push      = cmd_valid && cmd_ready && cmd_op <= 3'd4;
  assign exec      = state_q == EXEC;
  assign last      = exec && rem_q == '0;
  // Pop from idle, or back-to-back on the final cycle of the running command.
  assign pop       = !empty && (state_q == IDLE || last);
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  always_comb
    state_d = pop ? EXEC : (last ? IDLE : state_q);
  always_comb begin
    load           = exec && op_q == 3'd1;
    reverse        = exec && op_q == 3'd2;
    nibble_reverse = exec && op_q == 3'd3;
    rotateleft_b   = !(exec && op_q == 3'd4);
    done           = last;
    busy           = exec || !empty;
    err            = err_q;
    data           = data_q;
  end
  always_ff @(posedge clk)
    if (push) begin
      op_mem[wr_q]  <= cmd_op;
      dat_mem[wr_q] <= cmd_data;
      cnt_mem[wr_q] <= cmd_count;
    end
  always_ff @(posedge clk)
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      occ_q  <= '0;
      op_q   <= '0;
      data_q <= '0;
      rem_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= cmd_valid && cmd_ready && cmd_op > 3'd4;
      occ_q <= occ_q + OW'(push) - OW'(pop);
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) begin
        rd_q   <= rd_q + AW'(1);
        op_q   <= op_mem[rd_q];
        data_q <= dat_mem[rd_q];
        rem_q  <= cnt_mem[rd_q];
      end else if (exec && !last) begin
        rem_q <= rem_q - CNT_W'(1);
      end
    end
endmodule

// File: doc/reg_op_sequencer.md
Name: reg_op_sequencer

Overview:
Upstream control stage for the 8-bit shift/reverse register, register_8. It accepts operation commands through a valid/ready handshake and buffers them in a small FIFO. It then drives register_8's data, load, reverse, nibble_reverse and rotateleft_b inputs one operation per cycle, with a per-command repeat count. At most one register control is active in any cycle, so register_8's internal priority never matters.

Parameters:
DEPTH, 4, command FIFO depth in entries; must be a power of 2 and at least 2.
CNT_W, 4, width of the repeat-count field; a command executes cmd_count+1 cycles.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept; equals !full
cmd_op  input  3  0=NOP, 1=LOAD, 2=REVERSE, 3=NIBBLE, 4=ROTL; 5-7 illegal
cmd_data  input  8  load value, used by LOAD only
cmd_count  input  CNT_W  repeat count minus 1
data  output  8  to register_8.data
load  output  1  to register_8.load
reverse  output  1  to register_8.reverse
nibble_reverse  output  1  to register_8.nibble_reverse
rotateleft_b  output  1  to register_8.rotateleft_b; active-low
busy  output  1  high while in EXEC or while the FIFO is non-empty
done  output  1  one-cycle pulse on the last execution cycle of a command
err  output  1  one-cycle pulse when an illegal op is rejected

Behaviour:
- Reset: state=IDLE; FIFO emptied; cur_op=NOP; data=0x00; load, reverse and nibble_reverse = 0; rotateleft_b=1; done=0; err=0; cmd_ready=1.
- Reset asserted mid-operation aborts the current command and flushes the FIFO. Outputs take their reset values at the next edge.
- Enqueue: a transfer occurs when cmd_valid && cmd_ready at a clock edge.
  - Legal op (0-4): {op, data, count} is written at the FIFO tail.
  - Illegal op (5-7): nothing is written, and err=1 for the following cycle only.
- FIFO behaviour:
  - Pointers wrap modulo DEPTH. An occupancy counter runs from 0 to DEPTH.
  - A simultaneous push and pop leaves occupancy unchanged.
  - There is no bypass path: a command always spends at least one cycle in the FIFO.
- FSM, two states:
  - IDLE: if the FIFO is non-empty, pop the head into cur_op/cur_data/rem (rem=count) and go to EXEC. Otherwise stay in IDLE.
  - EXEC: drive the controls for cur_op.
    - If rem != 0: rem decrements, stay in EXEC.
    - If rem == 0: done=1 this cycle. Then, if the FIFO is non-empty, pop the next command at this edge (back-to-back, no bubble) and stay in EXEC. Otherwise go to IDLE.
- Latency: a command accepted at edge T is popped at edge T+1 if the FSM is idle. Its first control cycle is the cycle after edge T+1, so register_8 first acts on it at edge T+2.
- Control decode:
  - Outputs are decoded from registered state only; there is no combinational path from any cmd_* input to any control output.
  - In EXEC: load=(op==LOAD), reverse=(op==REVERSE), nibble_reverse=(op==NIBBLE), rotateleft_b=!(op==ROTL).
  - A NOP asserts no control for count+1 cycles and is used as a timed delay.
  - In IDLE, all controls are inactive and rotateleft_b=1.
- data holds cur_data from pop until the next pop; it is only meaningful while load=1.
- Repeat count: an all-ones count gives 2^CNT_W cycles. rem never underflows.
- Invariant: at most one of load, reverse, nibble_reverse and !rotateleft_b is high in any cycle.
- busy = (state==EXEC) || (occupancy != 0).

Test Plan:
1. Reset, then LOAD data=0xAA count=0 -> load=1 for exactly one cycle, at cycle T+2 after acceptance. data=0xAA, done pulses in the same cycle, and the downstream register holds 0xAA.
2. Queue LOAD 0x81 c=0, ROTL c=2, NIBBLE c=0, REVERSE c=0 -> controls are back-to-back with no gaps: 1 load, then 3 rotl, then 1 nibble, then 1 reverse. Downstream q goes 0x81 -> 0x03 -> 0x06 -> 0x0C -> 0xC0 -> 0x03. done pulses 4 times.
3. Hold cmd_valid=1 with 6 legal commands while the FSM is busy -> cmd_ready drops once occupancy=4. No command is lost or duplicated, and they execute in order.
4. cmd_op=6 -> nothing is enqueued, err=1 for one cycle, no control is asserted, and busy stays 0.
5. Assert rst during the 5th cycle of ROTL c=15 with 2 commands queued -> after the next edge, rotateleft_b=1, busy=0, cmd_ready=1, and the queued commands never execute.
6. NOP c=3 followed by LOAD 0x5A -> 4 cycles with all controls inactive and busy=1, then load=1 on the 5th cycle.
